// File: rtl/fp_pkg.sv
// Shared widths and arithmetic for the arbitrated floating-point multiplier.
// Fields are {sign, expo, mant}; the mantissa has no hidden bit.
package fp_pkg;

  localparam int NB_SIGN = 1;
  localparam int NB_EXPO = 4;
  localparam int NB_MANT = 8;
  localparam int NB      = NB_SIGN + NB_EXPO + NB_MANT;
  localparam int BIAS    = (2**NB_EXPO - 1) >> 1;

  typedef logic [NB-1:0]      fp_t;
  typedef logic [NB_EXPO-1:0] expo_t;
  typedef logic [NB_MANT-1:0] mant_t;

  // Operand pair plus the requester that issued it.
  typedef struct packed {
    fp_t  a;
    fp_t  b;
    logic id;
  } op_t;

  function automatic logic get_sign(input fp_t x);
    return x[NB-1];
  endfunction

  function automatic expo_t get_expo(input fp_t x);
    return x[NB_MANT +: NB_EXPO];
  endfunction

  function automatic mant_t get_mant(input fp_t x);
    return x[NB_MANT-1:0];
  endfunction

  // Exponent wraps modulo 2**NB_EXPO; mantissa is the truncated integer product.
  function automatic fp_t fp_mul(input fp_t a, input fp_t b);
    logic                   s;
    expo_t                  e;
    logic [2*NB_MANT-1:0]   p;
    s = get_sign(a) ^ get_sign(b);
    e = get_expo(a) + get_expo(b) - expo_t'(BIAS);
    p = {{NB_MANT{1'b0}}, get_mant(a)} * {{NB_MANT{1'b0}}, get_mant(b)};
    return {s, e, p[NB_MANT-1:0]};
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant, pointer flips to the other
// requester after every grant and holds otherwise.
module rr_arbiter_2 (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic ptr;  // 0 favours requester 0 on contention

  always_comb begin
    // NOTE: default assigned first so every path drives grant and no latch is inferred.
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset)
      ptr <= 1'b0;
    else if (|grant)
      ptr <= grant[0];
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Two requesters share one fp_mul datapath through a 2-stage pipeline
// (operand stage S1, result stage S2) with valid/ready flow control.
module fp_mult_arbiter
  import fp_pkg::*;
(
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_valid0,
  input  logic [NB-1:0] i_dataA0,
  input  logic [NB-1:0] i_dataB0,
  output logic          o_ready0,
  input  logic          i_valid1,
  input  logic [NB-1:0] i_dataA1,
  input  logic [NB-1:0] i_dataB1,
  output logic          o_ready1,
  output logic          o_valid,
  output logic [NB-1:0] o_data,
  output logic          o_id,
  input  logic          i_ready,
  output logic          o_busy
);

  logic       adv1;
  logic       adv2;
  logic       v1;
  op_t        s1;
  op_t        req_op;
  logic [1:0] grant;

  // A stage may load when it is empty or its contents move on this edge.
  assign adv2 = !o_valid || i_ready;
  assign adv1 = !v1 || adv2;

  rr_arbiter_2 u_arb (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .req     ({i_valid1, i_valid0}),
    .enable  (adv1 && !i_reset),
    .grant   (grant)
  );

  assign o_ready0 = grant[0];
  assign o_ready1 = grant[1];
  assign o_busy   = v1 || o_valid;
  assign req_op   = grant[1] ? {i_dataA1, i_dataB1, 1'b1}
                             : {i_dataA0, i_dataB0, 1'b0};

  always_ff @(posedge i_clock) begin
    // NOTE: non-blocking so S1 and S2 both see pre-edge values when they move together.
    if (i_reset) begin
      v1 <= 1'b0;
      // NOTE: operand registers are reset as well; cheap here and keeps S1 deterministic.
      s1 <= '0;
    end else if (adv1) begin
      v1 <= |grant;
      if (|grant)
        s1 <= req_op;
    end else begin
      v1 <= v1 && !adv2;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_id    <= 1'b0;
    end else if (adv2) begin
      o_valid <= v1;
      if (v1) begin
        o_data <= fp_mul(s1.a, s1.b);
        o_id   <= s1.id;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed vector table plus hand-written pipeline sequences and a random
// scoreboard run for fp_mult_arbiter.
module tb_fp_mult_arbiter;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_valid0, i_valid1, i_ready;
  logic [12:0] i_dataA0, i_dataB0, i_dataA1, i_dataB1;
  logic        o_ready0, o_ready1, o_valid, o_id, o_busy;
  logic [12:0] o_data;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_mult_arbiter dut (
    .i_clock  (clk),
    .i_reset  (i_reset),
    .i_valid0 (i_valid0),
    .i_dataA0 (i_dataA0),
    .i_dataB0 (i_dataB0),
    .o_ready0 (o_ready0),
    .i_valid1 (i_valid1),
    .i_dataA1 (i_dataA1),
    .i_dataB1 (i_dataB1),
    .o_ready1 (o_ready1),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_id     (o_id),
    .i_ready  (i_ready),
    .o_busy   (o_busy)
  );

  typedef struct {
    logic        id;
    logic [12:0] a;
    logic [12:0] b;
    logic [12:0] expect_data;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product written with plain integer arithmetic.
  function automatic logic [12:0] model(input logic [12:0] a, input logic [12:0] b);
    int s, e, m;
    s = int'(a[12]) ^ int'(b[12]);
    e = (int'(a[11:8]) + int'(b[11:8]) - 7 + 16) % 16;
    m = (int'(a[7:0]) * int'(b[7:0])) % 256;
    return 13'(s * 4096 + e * 256 + m);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_valid0 = 1'b0;
    i_valid1 = 1'b0;
    i_reset  = 1'b1;
    step();
    step();
    i_reset  = 1'b0;
  endtask

  task automatic run_single(input int idx, input vec_t v);
    i_valid0 = !v.id;
    i_valid1 = v.id;
    i_dataA0 = v.a; i_dataB0 = v.b;
    i_dataA1 = v.a; i_dataB1 = v.b;
    @(negedge clk);
    check($sformatf("vec%0d ready0", idx), o_ready0, !v.id);
    check($sformatf("vec%0d ready1", idx), o_ready1, v.id);
    step();
    i_valid0 = 1'b0;
    i_valid1 = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d early_valid", idx), o_valid, 0);
    @(negedge clk);
    check($sformatf("vec%0d valid", idx), o_valid, 1);
    check($sformatf("vec%0d data", idx), o_data, v.expect_data);
    check($sformatf("vec%0d id", idx), o_id, v.id);
    step();
  endtask

  logic [13:0] sb_q[$];

  initial begin
    logic        got;
    int          j, k, bubbles, cyc, acc, viol;
    logic        rv[2];
    logic [12:0] ra[2], rb[2];
    logic [13:0] exp_r;

    vecs[0] = '{1'b0, 13'h0702, 13'h0803, 13'h0806};
    vecs[1] = '{1'b1, 13'h1F10, 13'h1F20, 13'h0700};
    vecs[2] = '{1'b0, 13'h1702, 13'h0703, 13'h1706};
    vecs[3] = '{1'b1, 13'h0000, 13'h0000, 13'h0900};
    vecs[4] = '{1'b0, 13'h0FFF, 13'h07FF, 13'h0F01};
    vecs[5] = '{1'b1, 13'h1381, 13'h0402, 13'h1002};

    i_ready  = 1'b1;
    i_dataA0 = '0; i_dataB0 = '0; i_dataA1 = '0; i_dataB1 = '0;
    i_valid0 = 1'b0; i_valid1 = 1'b0;
    i_reset  = 1'b1;
    step();
    i_valid0 = 1'b1;
    @(negedge clk);
    check("reset ready0", o_ready0, 0);
    step();
    i_valid0 = 1'b0;
    i_reset  = 1'b0;
    @(negedge clk);
    check("reset valid", o_valid, 0);
    check("reset data", o_data, 0);
    check("reset id", o_id, 0);
    check("reset busy", o_busy, 0);
    step();

    for (int i = 0; i < 6; i++) run_single(i, vecs[i]);

    // Contention: both requesting for 4 cycles straight after reset.
    do_reset();
    i_dataA0 = 13'h0702; i_dataB0 = 13'h0803;
    i_dataA1 = 13'h1F10; i_dataB1 = 13'h1F20;
    for (int c = 0; c < 6; c++) begin
      i_valid0 = (c < 4);
      i_valid1 = (c < 4);
      @(negedge clk);
      if (c < 4) begin
        check($sformatf("cont%0d ready0", c), o_ready0, (c % 2) == 0);
        check($sformatf("cont%0d ready1", c), o_ready1, (c % 2) == 1);
      end
      check($sformatf("cont%0d valid", c), o_valid, c >= 2);
      if (c >= 2) begin
        check($sformatf("cont%0d id", c), o_id, (c % 2) == 1);
        check($sformatf("cont%0d data", c), o_data, (c % 2) ? 13'h0700 : 13'h0806);
      end
      step();
    end

    // Backpressure: consumer stalled while requester 0 streams.
    do_reset();
    i_ready  = 1'b0;
    i_dataB0 = 13'h0702;
    j = 0;
    for (int c = 0; c < 5; c++) begin
      i_valid0 = 1'b1;
      i_dataA0 = {1'b0, 4'd7, 8'(j + 1)};
      @(negedge clk);
      got = o_ready0;
      check($sformatf("bp%0d ready0", c), o_ready0, c < 2);
      if (c >= 2) begin
        check($sformatf("bp%0d held_data", c), o_data, 13'h0702);
        check($sformatf("bp%0d valid", c), o_valid, 1);
      end
      @(posedge clk);
      if (got) j++;
      #1;
    end
    check("bp accepted", j, 2);
    i_ready = 1'b1;
    k = 0; bubbles = 0; cyc = 0;
    while (k < 6 && cyc < 40) begin
      i_valid0 = (j < 6);
      i_dataA0 = {1'b0, 4'd7, 8'(j + 1)};
      @(negedge clk);
      got = o_ready0;
      if (o_valid) begin
        check($sformatf("bp drain%0d", k), o_data, 13'(16'h0700 + 2 * (k + 1)));
        k++;
      end else begin
        bubbles++;
      end
      @(posedge clk);
      if (got) j++;
      #1;
      cyc++;
    end
    check("bp results", k, 6);
    check("bp bubbles", bubbles, 0);

    // Reset with both stages full and the pointer favouring requester 1.
    i_ready  = 1'b0;
    i_valid0 = 1'b0;
    i_valid1 = 1'b1;
    step();
    i_valid0 = 1'b1;
    i_valid1 = 1'b0;
    step();
    i_valid1 = 1'b1;
    @(negedge clk);
    check("mid pre_id", o_id, 1);
    check("mid pre_busy", o_busy, 1);
    step();
    i_reset = 1'b1;
    @(negedge clk);
    check("mid rst ready0", o_ready0, 0);
    check("mid rst ready1", o_ready1, 0);
    step();
    i_reset = 1'b0;
    @(negedge clk);
    check("mid valid", o_valid, 0);
    check("mid busy", o_busy, 0);
    check("mid id", o_id, 0);
    check("mid first_grant0", o_ready0, 1);
    check("mid first_grant1", o_ready1, 0);
    step();
    i_valid0 = 1'b0;
    i_valid1 = 1'b0;
    @(negedge clk);
    check("mid no_stale", o_valid, 0);
    i_ready = 1'b1;
    repeat (4) step();

    // Random traffic against the scoreboard.
    do_reset();
    acc = 0; cyc = 0; viol = 0;
    rv[0] = 1'b0; rv[1] = 1'b0;
    ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0;
    while (acc < 10000 && cyc < 60000) begin
      for (int r = 0; r < 2; r++) begin
        if (!rv[r]) begin
          rv[r] = 1'($urandom_range(0, 1));
          ra[r] = 13'($urandom);
          rb[r] = 13'($urandom);
        end
      end
      i_valid0 = rv[0]; i_dataA0 = ra[0]; i_dataB0 = rb[0];
      i_valid1 = rv[1]; i_dataA1 = ra[1]; i_dataB1 = rb[1];
      i_ready  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (o_ready0 && o_ready1) viol++;
      if (o_ready0) begin sb_q.push_back({1'b0, model(ra[0], rb[0])}); acc++; end
      if (o_ready1) begin sb_q.push_back({1'b1, model(ra[1], rb[1])}); acc++; end
      if (o_valid && i_ready) begin
        exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : 14'h3FFF;
        check("rand result", {o_id, o_data}, exp_r);
      end
      if (o_ready0) rv[0] = 1'b0;
      if (o_ready1) rv[1] = 1'b0;
      step();
      cyc++;
    end
    check("rand accepts", acc >= 10000, 1);
    i_valid0 = 1'b0;
    i_valid1 = 1'b0;
    i_ready  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_valid) begin
        exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : 14'h3FFF;
        check("rand drain", {o_id, o_data}, exp_r);
      end
      step();
    end
    check("rand leftover", sb_q.size(), 0);
    check("rand one_hot_ready", viol, 0);
    check("rand idle_busy", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
